// File: rtl/param_reg_file_pkg.sv
// Shared types and default parameter values for the parameterised register file.
package param_reg_file_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_ADDR_W      = 3;
  localparam int DEF_HARDWIRE_R0 = 0;
  localparam int DEF_BYPASS      = 1;

endpackage

// File: rtl/rf_clear_fsm.sv
// Clear-sweep controller: walks every register index once, writing zero, then returns to idle.
module rf_clear_fsm
  import param_reg_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_clear_req,
  output logic              o_state_dbg,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_idx
);

  rf_state_t         r_state;
  rf_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_clr_idx;
  logic [ADDR_W-1:0] w_clr_idx_nxt;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state   <= RF_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  // clear_req is only honoured from idle, so a running sweep never restarts or stretches.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    case (r_state)
      RF_IDLE: begin
        if (i_clear_req) begin
          w_state_nxt   = RF_CLEAR;
          w_clr_idx_nxt = '0;
        end
      end
      RF_CLEAR: begin
        w_clr_idx_nxt = r_clr_idx + ADDR_W'(1);
        if (r_clr_idx == {ADDR_W{1'b1}}) begin
          w_state_nxt = RF_IDLE;
        end
      end
      default: w_state_nxt = RF_IDLE;
    endcase
  end

  assign o_state_dbg = r_state;
  assign o_busy      = i_reset | (r_state == RF_CLEAR);
  assign o_clr_we    = (r_state == RF_CLEAR);
  assign o_clr_idx   = r_clr_idx;

endmodule

// File: rtl/param_reg_file.sv
// Two-read, one-write register file with optional write-through bypass, hardwired r0
// and a self-timed clear sweep used both after reset and on clear_req.
module param_reg_file
  import param_reg_file_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int HARDWIRE_R0 = DEF_HARDWIRE_R0,
  parameter int BYPASS      = DEF_BYPASS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              clear_req,
  output logic              busy,
  output logic              write_drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic              r_write_drop;
  logic              w_state_dbg;
  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_idx;
  logic              w_wr_r0_blocked;
  logic              w_wr_commit;
  logic              w_fwd1;
  logic              w_fwd2;

  rf_clear_fsm #(
    .ADDR_W(ADDR_W)
  ) u_clear_fsm (
    .clk        (clk),
    .i_reset    (reset),
    .i_clear_req(clear_req),
    .o_state_dbg(w_state_dbg),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_idx  (w_clr_idx)
  );

  // A write aimed at a hardwired r0 is not a real write, so it neither commits nor counts as dropped.
  assign w_wr_r0_blocked = (HARDWIRE_R0 != 0) && (write_reg == '0);
  assign w_wr_commit     = write_en & ~w_busy & ~w_wr_r0_blocked;

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_regs[w_clr_idx] <= '0;
    end else if (w_wr_commit) begin
      r_regs[write_reg] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_write_drop <= 1'b0;
    end else if (w_clr_we && write_en && !w_wr_r0_blocked) begin
      r_write_drop <= 1'b1;
    end
  end

  assign w_fwd1 = (BYPASS != 0) && write_en && (write_reg == read_reg1);
  assign w_fwd2 = (BYPASS != 0) && write_en && (write_reg == read_reg2);

  always_comb begin
    read_data1 = '0;
    if (!w_busy && !((HARDWIRE_R0 != 0) && (read_reg1 == '0))) begin
      read_data1 = w_fwd1 ? write_data : r_regs[read_reg1];
    end
  end

  always_comb begin
    read_data2 = '0;
    if (!w_busy && !((HARDWIRE_R0 != 0) && (read_reg2 == '0))) begin
      read_data2 = w_fwd2 ? write_data : r_regs[read_reg2];
    end
  end

  assign busy       = w_busy;
  assign write_drop = r_write_drop;

endmodule

// File: tb/tb_param_reg_file.sv
// Bench for param_reg_file: two instances (bypass/no-r0 and no-bypass/hardwired-r0)
// share stimulus and are compared each cycle against a behavioural register model.
module tb_param_reg_file;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] rr1, rr2, wr;
  logic [DW-1:0] wd;
  logic          we, clr;

  logic [DW-1:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic          busy_a, busy_b, drop_a, drop_b;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  param_reg_file dut_a (
    .clk(clk), .reset(reset),
    .read_reg1(rr1), .read_reg2(rr2),
    .read_data1(rd1_a), .read_data2(rd2_a),
    .write_en(we), .write_reg(wr), .write_data(wd),
    .clear_req(clr), .busy(busy_a), .write_drop(drop_a)
  );

  param_reg_file #(.BYPASS(0), .HARDWIRE_R0(1)) dut_b (
    .clk(clk), .reset(reset),
    .read_reg1(rr1), .read_reg2(rr2),
    .read_data1(rd1_b), .read_data2(rd2_b),
    .write_en(we), .write_reg(wr), .write_data(wd),
    .clear_req(clr), .busy(busy_b), .write_drop(drop_b)
  );

  // Behavioural model: index 0 = dut_a, index 1 = dut_b.
  bit            m_bp [2] = '{1'b1, 1'b0};
  bit            m_hw [2] = '{1'b0, 1'b1};
  logic [DW-1:0] m_regs [2][DEPTH];
  bit            m_drop [2];
  int            m_busy_left = 0;
  bit            m_valid = 1'b0;

  function automatic bit m_busy();
    return (reset === 1'b1) || (m_busy_left > 0);
  endfunction

  function automatic logic [DW-1:0] m_read(input int k, input logic [AW-1:0] a);
    if (m_busy()) return '0;
    if (m_hw[k] && a == 0) return '0;
    if (m_bp[k] && we && wr == a) return wd;
    return m_regs[k][a];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid     = 1'b1;
      m_busy_left = DEPTH;
      for (int k = 0; k < 2; k++) begin
        m_drop[k] = 1'b0;
        for (int r = 0; r < DEPTH; r++) m_regs[k][r] = '0;
      end
    end else if (m_valid) begin
      if (m_busy_left > 0) begin
        for (int k = 0; k < 2; k++)
          if (we && !(m_hw[k] && wr == 0)) m_drop[k] = 1'b1;
        m_busy_left--;
      end else begin
        for (int k = 0; k < 2; k++)
          if (we && !(m_hw[k] && wr == 0)) m_regs[k][wr] = wd;
        if (clr) begin
          for (int k = 0; k < 2; k++)
            for (int r = 0; r < DEPTH; r++) m_regs[k][r] = '0;
          m_busy_left = DEPTH;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy_a", {31'b0, busy_a}, {31'b0, m_busy()});
      chk("busy_b", {31'b0, busy_b}, {31'b0, m_busy()});
      chk("drop_a", {31'b0, drop_a}, {31'b0, m_drop[0]});
      chk("drop_b", {31'b0, drop_b}, {31'b0, m_drop[1]});
      chk("rd1_a", {24'b0, rd1_a}, {24'b0, m_read(0, rr1)});
      chk("rd2_a", {24'b0, rd2_a}, {24'b0, m_read(0, rr2)});
      chk("rd1_b", {24'b0, rd1_b}, {24'b0, m_read(1, rr1)});
      chk("rd2_b", {24'b0, rd2_b}, {24'b0, m_read(1, rr2)});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Counts consecutive busy cycles starting with the current one; bounded.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy_a) n++;
      else break;
    end
  endtask

  int n;

  initial begin
    reset = 1'b1; clr = 1'b0; we = 1'b0; wr = '0; wd = '0; rr1 = '0; rr2 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    count_busy(n);
    chk("rst_busy_len", n, 8);
    for (int i = 0; i < DEPTH; i++) begin
      rr1 = AW'(i); rr2 = AW'(DEPTH - 1 - i);
      #1;
      chk("post_rst_rd_a", {24'b0, rd1_a}, 32'h00);
      chk("post_rst_rd_b", {24'b0, rd2_b}, 32'h00);
    end

    cyc(); we = 1'b1; wr = 3'd3; wd = 8'hA5; rr1 = 3'd3; rr2 = 3'd3;
    #1;
    chk("byp_a_same", {24'b0, rd1_a}, 32'hA5);
    chk("byp_a_port2", {24'b0, rd2_a}, 32'hA5);
    chk("nobyp_b_same", {24'b0, rd1_b}, 32'h00);
    cyc(); we = 1'b0;
    #1;
    chk("nobyp_b_next", {24'b0, rd1_b}, 32'hA5);
    chk("byp_a_next", {24'b0, rd1_a}, 32'hA5);

    cyc(); we = 1'b1; wr = 3'd0; wd = 8'hFF; rr1 = 3'd0;
    #1;
    chk("hw0_b_same", {24'b0, rd1_b}, 32'h00);
    chk("r0_a_byp", {24'b0, rd1_a}, 32'hFF);
    cyc(); we = 1'b0;
    #1;
    chk("hw0_b_later", {24'b0, rd1_b}, 32'h00);
    chk("r0_a_later", {24'b0, rd1_a}, 32'hFF);
    chk("hw0_b_nodrop", {31'b0, drop_b}, 32'h0);

    cyc(); clr = 1'b1;
    cyc(); clr = 1'b0; we = 1'b1; wr = 3'd5; wd = 8'h3C;
    #1;
    chk("sweep_busy", {31'b0, busy_a}, 32'h1);
    cyc(); we = 1'b0;
    #1;
    chk("drop_set_a", {31'b0, drop_a}, 32'h1);
    chk("drop_set_b", {31'b0, drop_b}, 32'h1);
    count_busy(n);
    chk("sweep_rest_len", n, 7);
    rr1 = 3'd5; rr2 = 3'd3;
    #1;
    chk("r5_zero", {24'b0, rd1_a}, 32'h00);
    chk("r3_zero", {24'b0, rd2_a}, 32'h00);

    cyc(); we = 1'b1; wr = 3'd2; wd = 8'h11; rr1 = 3'd2;
    cyc(); wd = 8'h22; clr = 1'b1;
    #1;
    chk("coll_byp_a", {24'b0, rd1_a}, 32'h22);
    chk("coll_old_b", {24'b0, rd1_b}, 32'h11);
    cyc(); we = 1'b0; clr = 1'b0;
    count_busy(n);
    chk("coll_busy_len", n, 8);
    #1;
    chk("coll_r2_a", {24'b0, rd1_a}, 32'h00);
    chk("coll_r2_b", {24'b0, rd1_b}, 32'h00);
    chk("drop_sticky", {31'b0, drop_a}, 32'h1);

    cyc(); clr = 1'b1;
    cyc(); clr = 1'b0;
    repeat (4) cyc();
    reset = 1'b1;
    #1;
    chk("rst_busy", {31'b0, busy_a}, 32'h1);
    chk("rst_rd_zero", {24'b0, rd1_a}, 32'h00);
    cyc(); reset = 1'b0;
    #1;
    chk("rst_drop_clr", {31'b0, drop_a}, 32'h0);
    count_busy(n);
    chk("rst_mid_len", n, 8);

    for (int c = 0; c < 1500; c++) begin
      cyc();
      reset = ($urandom_range(0, 99) == 0);
      clr   = ($urandom_range(0, 11) == 0);
      we    = 1'($urandom_range(0, 1));
      wr    = AW'($urandom_range(0, DEPTH - 1));
      wd    = DW'($urandom_range(0, 255));
      rr1   = AW'($urandom_range(0, DEPTH - 1));
      rr2   = ($urandom_range(0, 3) == 0) ? rr1 : AW'($urandom_range(0, DEPTH - 1));
    end
    cyc(); reset = 1'b0; clr = 1'b0; we = 1'b0;
    repeat (12) cyc();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
